sram_ctrl: RTL

- Clocked controller that turns single-beat processor-side requests into timed, byte-masked access cycles on an external asynchronous SRAM.
- Target part: IS62WV12816-class, 128K x 16 with CS1#/CS2/OE#/WE#/LB#/UB#.
- Generalises the data RAM to parametrised data width, address width, byte-lane count and programmable wait states.
- Sits between the data-memory port of the core and the board SRAM pins; the top level builds the inout pad from sram_dq_o/sram_dq_oe/sram_dq_i.

---
 rtl/sram_ctrl.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/sram_ctrl.sv
// Registered controller for an asynchronous SRAM (IS62WV12816 class): single-beat
// requests become byte-masked read/write cycles with programmable strobe widths.
module sram_ctrl #(
    parameter int ADDR_W  = 17,
    parameter int DATA_W  = 16,
    parameter int RD_WAIT = 2,
    parameter int WR_WAIT = 2,
    parameter int TURN    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req,
    output logic                  ready,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   be,
    output logic                  rvalid,
    output logic [DATA_W-1:0]     rdata,
    output logic                  wdone,
    output logic [ADDR_W-1:0]     sram_a,
    output logic                  sram_cs1_n,
    output logic                  sram_cs2,
    output logic                  sram_oe_n,
    output logic                  sram_we_n,
    output logic [DATA_W/8-1:0]   sram_be_n,
    output logic [DATA_W-1:0]     sram_dq_o,
    output logic                  sram_dq_oe,
    input  logic [DATA_W-1:0]     sram_dq_i
);

    localparam int NB       = DATA_W / 8;
    localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ? ((RD_WAIT > TURN) ? RD_WAIT : TURN)
                                                  : ((WR_WAIT > TURN) ? WR_WAIT : TURN);
    localparam int CW       = $clog2(MAX_WAIT + 1);
    // The response-pulse cycle is always a non-ready cycle, so it doubles as the
    // first turnaround cycle and TURN = 0 still costs that one cycle.
    localparam int TURN_CYC = (TURN > 0) ? TURN : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_WR_SETUP, S_WR_PULSE, S_WR_HOLD, S_TURN
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [NB-1:0]       be_q, be_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                ready_q, ready_d;
    logic                rvalid_q, rvalid_d;
    logic                wdone_q, wdone_d;
    logic                cs1_n_q, cs1_n_d;
    logic                cs2_q, cs2_d;
    logic                oe_n_q, oe_n_d;
    logic                we_n_q, we_n_d;
    logic [NB-1:0]       be_n_q, be_n_d;
    logic                dq_oe_q, dq_oe_d;

    function automatic logic [DATA_W-1:0] lane_mask(input logic [NB-1:0] lanes);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int i = 0; i < NB; i++) m[i*8 +: 8] = {8{lanes[i]}};
        return m;
    endfunction

    // NOTE: every next-state variable gets a default before the case, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        wdone_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req && ready_q) begin
                    addr_d  = addr;
                    wdata_d = wdata;
                    be_d    = be;
                    if (be == '0) begin
                        state_d = S_TURN;
                        cnt_d   = '0;
                        if (we) begin
                            wdone_d = 1'b1;
                        end else begin
                            rvalid_d = 1'b1;
                            rdata_d  = '0;
                        end
                    end else if (we) begin
                        state_d = S_WR_SETUP;
                    end else begin
                        state_d = S_RD;
                        cnt_d   = CW'(RD_WAIT - 1);
                    end
                end
            end
            S_RD: begin
                if (cnt_q == '0) begin
                    rdata_d  = sram_dq_i & lane_mask(be_q);
                    rvalid_d = 1'b1;
                    state_d  = S_TURN;
                    cnt_d    = CW'(TURN_CYC - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_WR_SETUP: begin
                state_d = S_WR_PULSE;
                cnt_d   = CW'(WR_WAIT - 1);
            end
            S_WR_PULSE: begin
                if (cnt_q == '0) state_d = S_WR_HOLD;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_WR_HOLD: begin
                wdone_d = 1'b1;
                state_d = S_TURN;
                cnt_d   = CW'(TURN_CYC - 1);
            end
            S_TURN: begin
                if (cnt_q == '0) state_d = S_IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // Pin values are decoded from the next state so they register together with it.
        ready_d = (state_d == S_IDLE);
        cs1_n_d = 1'b1;
        cs2_d   = 1'b0;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        be_n_d  = '1;
        dq_oe_d = 1'b0;
        case (state_d)
            S_RD: begin
                cs1_n_d = 1'b0;
                cs2_d   = 1'b1;
                oe_n_d  = 1'b0;
                be_n_d  = ~be_d;
            end
            S_WR_SETUP, S_WR_PULSE, S_WR_HOLD: begin
                cs1_n_d = 1'b0;
                cs2_d   = 1'b1;
                be_n_d  = ~be_d;
                dq_oe_d = 1'b1;
                we_n_d  = (state_d != S_WR_PULSE);
            end
            default: ;
        endcase
    end

    // NOTE: state flops use non-blocking assignments; the async reset drops every
    // strobe at once, which is what aborts an access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            rdata_q  <= '0;
            ready_q  <= 1'b0;
            rvalid_q <= 1'b0;
            wdone_q  <= 1'b0;
            cs1_n_q  <= 1'b1;
            cs2_q    <= 1'b0;
            oe_n_q   <= 1'b1;
            we_n_q   <= 1'b1;
            be_n_q   <= '1;
            dq_oe_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            rdata_q  <= rdata_d;
            ready_q  <= ready_d;
            rvalid_q <= rvalid_d;
            wdone_q  <= wdone_d;
            cs1_n_q  <= cs1_n_d;
            cs2_q    <= cs2_d;
            oe_n_q   <= oe_n_d;
            we_n_q   <= we_n_d;
            be_n_q   <= be_n_d;
            dq_oe_q  <= dq_oe_d;
        end
    end

    assign ready      = ready_q;
    assign rvalid     = rvalid_q;
    assign wdone      = wdone_q;
    assign rdata      = rdata_q;
    assign sram_a     = addr_q;
    assign sram_dq_o  = wdata_q;
    assign sram_cs1_n = cs1_n_q;
    assign sram_cs2   = cs2_q;
    assign sram_oe_n  = oe_n_q;
    assign sram_we_n  = we_n_q;
    assign sram_be_n  = be_n_q;
    assign sram_dq_oe = dq_oe_q;

endmodule
